ctrl_paint_multi: RTL



---
 rtl/ctrl_paint_multi_pkg.sv | 31 +++
 rtl/ctrl_paint_multi_if.sv | 30 +++
 rtl/ctrl_paint_multi_coord_map.sv | 39 +++
 rtl/ctrl_paint_multi.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_paint_multi_pkg.sv
// Shared types and helpers for the paint controller: sequencer states,
// default overlay/erase colours, coordinate clamp and row-split bank math.
package paint_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    RESTORE  = 3'd1,
    STAMP    = 3'd2,
    SAVE_RD  = 3'd3,
    SAVE_CAP = 3'd4,
    CURSOR   = 3'd5
  } state_t;

  localparam logic [11:0] CURSOR_COLOR_DEF = 12'h000;
  localparam logic [11:0] BG_COLOR_DEF     = 12'hFFF;

  function automatic int clamp_coord(input int v, input int max_v);
    if (v < 0) return 0;
    if (v > max_v) return max_v;
    return v;
  endfunction

  function automatic int bank_of(input int y, input int rows_per_bank);
    return y / rows_per_bank;
  endfunction

  function automatic int row_offset(input int y, input int rows_per_bank);
    return y % rows_per_bank;
  endfunction

endpackage

// File: rtl/ctrl_paint_multi_if.sv
// Mouse/brush inputs and banked frame-memory bus of the paint controller.
// master = controller side, slave = mouse path plus frame memories.
interface ctrl_paint_multi_if #(
  parameter int BANKS  = 2,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12
);
  logic signed [8:0]       PS2_Xdata;
  logic signed [8:0]       PS2_Ydata;
  logic                    btn_left;
  logic                    btn_right;
  logic [DATA_W-1:0]       paint_color;
  logic [1:0]              brush_size;
  logic [BANKS*DATA_W-1:0] rdata;
  logic [BANKS-1:0]        wr;
  logic [ADDR_W-1:0]       address;
  logic [DATA_W-1:0]       wdata;
  logic                    busy;
  logic                    paint_permanent;

  modport master (
    input  PS2_Xdata, PS2_Ydata, btn_left, btn_right, paint_color, brush_size, rdata,
    output wr, address, wdata, busy, paint_permanent
  );

  modport slave (
    output PS2_Xdata, PS2_Ydata, btn_left, btn_right, paint_color, brush_size, rdata,
    input  wr, address, wdata, busy, paint_permanent
  );
endinterface

// File: rtl/ctrl_paint_multi_coord_map.sv
// Combinational clamp of a signed pixel coordinate plus row-split bank and
// in-bank address; in_range flags the unclamped input as on-canvas.
module paint_coord_map
  import paint_pkg::*;
#(
  parameter int COLS   = 64,
  parameter int ROWS   = 64,
  parameter int BANKS  = 2,
  parameter int ADDR_W = 12,
  parameter int IN_W   = 11,
  parameter int XW     = $clog2(COLS),
  parameter int YW     = $clog2(ROWS),
  parameter int BW     = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic signed [IN_W-1:0] x_in,
  input  logic signed [IN_W-1:0] y_in,
  output logic [XW-1:0]          x_c,
  output logic [YW-1:0]          y_c,
  output logic [BW-1:0]          bank,
  output logic [ADDR_W-1:0]      address,
  output logic                   in_range
);
  localparam int RPB = ROWS / BANKS;

  int xr, yr, xi, yi;

  always_comb begin
    xr       = int'(x_in);
    yr       = int'(y_in);
    xi       = clamp_coord(xr, COLS - 1);
    yi       = clamp_coord(yr, ROWS - 1);
    x_c      = XW'(xi);
    y_c      = YW'(yi);
    bank     = BW'(bank_of(yi, RPB));
    address  = ADDR_W'(row_offset(yi, RPB) * COLS + xi);
    in_range = (xr >= 0) && (xr < COLS) && (yr >= 0) && (yr < ROWS);
  end

endmodule

// File: rtl/ctrl_paint_multi.sv
// Paint controller: restore underlay, stamp square brush, save new underlay,
// draw cursor. Optional erase brush enabled by defining PAINT_ERASE_EN.
module ctrl_paint_multi
  import paint_pkg::*;
#(
  parameter int COLS   = 64,
  parameter int ROWS   = 64,
  parameter int BANKS  = 2,
  parameter int DATA_W = 12,
  parameter int ADDR_W = 12,
  parameter logic [DATA_W-1:0] CURSOR_COLOR = DATA_W'(CURSOR_COLOR_DEF),
  parameter logic [DATA_W-1:0] BG_COLOR     = DATA_W'(BG_COLOR_DEF)
) (
  input logic              clk,
  input logic              reset,
  ctrl_paint_multi_if.master bus
);
  localparam int XW   = $clog2(COLS);
  localparam int YW   = $clog2(ROWS);
  localparam int BW   = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam int MW   = (XW > YW) ? XW : YW;
  localparam int IN_W = ((MW > 9) ? MW : 9) + 2;

  state_t state_reg, state_next;

  logic [XW-1:0]     cur_x_reg, tgt_x_reg, tgt_x_next, in_x;
  logic [YW-1:0]     cur_y_reg, tgt_y_reg, tgt_y_next, in_y;
  logic [BW-1:0]     cur_bank_reg, tgt_bank_reg, tgt_bank_next, in_bank, br_bank;
  logic [ADDR_W-1:0] cur_addr_reg, tgt_addr_reg, tgt_addr_next, in_addr, br_addr;
  logic              btn_l_reg, btn_l_next, btn_prev_reg;
  logic [DATA_W-1:0] color_reg, color_next, stamp_color;
  logic [1:0]        size_reg, size_next, dx_reg, dx_next, dy_reg, dy_next;
  logic [DATA_W-1:0] saved_reg;
  logic              saved_valid_reg;
  logic              trigger, stamp_last, br_in_range;
  logic signed [IN_W-1:0] cur_x_in, cur_y_in, br_x_in, br_y_in;

  logic [BANKS-1:0]  wr_reg, wr_next;
  logic [ADDR_W-1:0] address_reg, address_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic              busy_reg, busy_next, pp_reg, pp_next;

  logic              unused_cur_in_range;
  logic [XW-1:0]     unused_br_x;
  logic [YW-1:0]     unused_br_y;

  assign cur_x_in = IN_W'(bus.PS2_Xdata);
  assign cur_y_in = IN_W'(bus.PS2_Ydata);

  paint_coord_map #(
    .COLS(COLS), .ROWS(ROWS), .BANKS(BANKS), .ADDR_W(ADDR_W), .IN_W(IN_W)
  ) u_cursor_map (
    .x_in(cur_x_in), .y_in(cur_y_in), .x_c(in_x), .y_c(in_y),
    .bank(in_bank), .address(in_addr), .in_range(unused_cur_in_range)
  );

  // Brush pixel is the (possibly just latched) top-left plus the offset being issued next cycle.
  always_comb begin
    br_x_in = IN_W'(int'(tgt_x_next) + int'(dx_next));
    br_y_in = IN_W'(int'(tgt_y_next) + int'(dy_next));
  end

  paint_coord_map #(
    .COLS(COLS), .ROWS(ROWS), .BANKS(BANKS), .ADDR_W(ADDR_W), .IN_W(IN_W)
  ) u_brush_map (
    .x_in(br_x_in), .y_in(br_y_in), .x_c(unused_br_x), .y_c(unused_br_y),
    .bank(br_bank), .address(br_addr), .in_range(br_in_range)
  );

`ifdef PAINT_ERASE_EN
  logic btn_r_reg, btn_r_next;
  always_comb begin
    btn_r_next  = trigger ? bus.btn_right : btn_r_reg;
    stamp_color = btn_r_next ? BG_COLOR : color_next;
  end
`else
  logic unused_btn_right;
  assign unused_btn_right = bus.btn_right;
  always_comb stamp_color = color_next;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    trigger       = (state_reg == IDLE) &&
                    ((in_x != cur_x_reg) || (in_y != cur_y_reg) || (bus.btn_left && !btn_prev_reg));
    tgt_x_next    = trigger ? in_x            : tgt_x_reg;
    tgt_y_next    = trigger ? in_y            : tgt_y_reg;
    tgt_bank_next = trigger ? in_bank         : tgt_bank_reg;
    tgt_addr_next = trigger ? in_addr         : tgt_addr_reg;
    btn_l_next    = trigger ? bus.btn_left    : btn_l_reg;
    color_next    = trigger ? bus.paint_color : color_reg;
    size_next     = trigger ? bus.brush_size  : size_reg;
    stamp_last    = (dx_reg == size_reg) && (dy_reg == size_reg);

    state_next = state_reg;
    case (state_reg)
      IDLE:     if (trigger) state_next = saved_valid_reg ? RESTORE : (btn_l_next ? STAMP : SAVE_RD);
      RESTORE:  state_next = btn_l_reg ? STAMP : SAVE_RD;
      STAMP:    if (stamp_last) state_next = SAVE_RD;
      SAVE_RD:  state_next = SAVE_CAP;
      SAVE_CAP: state_next = CURSOR;
      CURSOR:   state_next = IDLE;
      default:  state_next = IDLE;
    endcase

    // Row-major walk; the offset always restarts at 0 on STAMP entry.
    dx_next = '0;
    dy_next = '0;
    if (state_next == STAMP && state_reg == STAMP) begin
      if (dx_reg == size_reg) begin
        dy_next = dy_reg + 2'd1;
      end else begin
        dx_next = dx_reg + 2'd1;
        dy_next = dy_reg;
      end
    end
  end

  // Outputs are decoded from the upcoming state so they register in step with it.
  always_comb begin
    wr_next      = '0;
    address_next = '0;
    wdata_next   = '0;
    pp_next      = 1'b0;
    busy_next    = (state_next != IDLE);
    case (state_next)
      RESTORE: begin
        wr_next      = BANKS'(1) << cur_bank_reg;
        address_next = cur_addr_reg;
        wdata_next   = saved_reg;
      end
      STAMP: begin
        wr_next      = br_in_range ? (BANKS'(1) << br_bank) : '0;
        address_next = br_addr;
        wdata_next   = stamp_color;
        pp_next      = br_in_range;
      end
      SAVE_RD, SAVE_CAP: address_next = tgt_addr_next;
      CURSOR: begin
        wr_next      = BANKS'(1) << tgt_bank_next;
        address_next = tgt_addr_next;
        wdata_next   = CURSOR_COLOR;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_reg          <= '0;
      address_reg     <= '0;
      wdata_reg       <= '0;
      busy_reg        <= 1'b0;
      pp_reg          <= 1'b0;
      saved_valid_reg <= 1'b0;
      saved_reg       <= '0;
      btn_prev_reg    <= 1'b0;
      cur_x_reg       <= '0;
      cur_y_reg       <= '0;
      cur_bank_reg    <= '0;
      cur_addr_reg    <= '0;
      tgt_x_reg       <= '0;
      tgt_y_reg       <= '0;
      tgt_bank_reg    <= '0;
      tgt_addr_reg    <= '0;
      btn_l_reg       <= 1'b0;
      color_reg       <= '0;
      size_reg        <= '0;
      dx_reg          <= '0;
      dy_reg          <= '0;
`ifdef PAINT_ERASE_EN
      btn_r_reg       <= 1'b0;
`endif
    end else begin
      wr_reg       <= wr_next;
      address_reg  <= address_next;
      wdata_reg    <= wdata_next;
      busy_reg     <= busy_next;
      pp_reg       <= pp_next;
      tgt_x_reg    <= tgt_x_next;
      tgt_y_reg    <= tgt_y_next;
      tgt_bank_reg <= tgt_bank_next;
      tgt_addr_reg <= tgt_addr_next;
      btn_l_reg    <= btn_l_next;
      color_reg    <= color_next;
      size_reg     <= size_next;
      dx_reg       <= dx_next;
      dy_reg       <= dy_next;
`ifdef PAINT_ERASE_EN
      btn_r_reg    <= btn_r_next;
`endif
      if (state_reg == IDLE) btn_prev_reg <= bus.btn_left;
      if (state_reg == SAVE_CAP) begin
        saved_reg       <= bus.rdata[tgt_bank_reg*DATA_W +: DATA_W];
        saved_valid_reg <= 1'b1;
      end
      if (state_reg == CURSOR) begin
        cur_x_reg    <= tgt_x_reg;
        cur_y_reg    <= tgt_y_reg;
        cur_bank_reg <= tgt_bank_reg;
        cur_addr_reg <= tgt_addr_reg;
      end
    end
  end

  assign bus.wr              = wr_reg;
  assign bus.address         = address_reg;
  assign bus.wdata           = wdata_reg;
  assign bus.busy            = busy_reg;
  assign bus.paint_permanent = pp_reg;

endmodule
